mt9v032_link_monitor: RTL and testbench
=======================================

Name: mt9v032_link_monitor

Overview:
Multi-camera link health and frame-alignment monitor in the clk_px domain, fed by the per-camera deserializer/post-processing outputs.
- Replaces the single fixed ready counter with per-channel link state machines, a configurable hold-off and a per-channel enable mask.
- Checks that frames start together across cameras and counts alignment errors and link losses.
- Requests retraining of channels that repeatedly fail to stabilise.

Parameters:
WIDTH, 2, number of camera channels (>=1)
HOLDOFF_BITS, 12, hold-off counter width; a channel must be stable for 2^HOLDOFF_BITS cycles
SKEW_MAX, 16, max cycles between first and last frame_valid rising edge in one frame (>=1)
ERR_BITS, 8, width of each saturating error counter
RETRAIN_THRESH, 4, consecutive hold-off failures before retrain_req pulses (>=1)

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous, active-high reset
chan_en  in  WIDTH  per-channel enable; disabled channels are ignored
train_done  in  WIDTH  per-channel word-alignment done
iod_ready  in  1  phase-detector calibration complete (shared)
frame_valid  in  WIDTH  per-channel frame_valid
line_valid  in  WIDTH  per-channel line_valid
chan_rdy  out  WIDTH  channel j is in UP state
rdy  out  1  all enabled channels UP, at least one enabled
frame_start  out  1  one-cycle pulse: aligned frame start on all enabled channels
sync_err  out  1  one-cycle pulse: alignment violation
sync_err_cnt  out  ERR_BITS  saturating count of sync_err
lost_cnt  out  WIDTH*ERR_BITS  per-channel saturating count of UP->DOWN transitions, slice j*ERR_BITS
retrain_req  out  WIDTH  one-cycle pulse per channel requesting retrain
line_err_cnt  out  ERR_BITS  line_valid-outside-frame count (see Optional Feature)

Behaviour:
- Reset: every output 0; all channel FSMs in DOWN; counters cleared; registered frame_valid history set to 1, so a high level at reset release is not an edge.
- Channel ok(j) = chan_en[j] & train_done[j] & iod_ready.
- Per-channel FSM, states DOWN / HOLDOFF / UP:
  - DOWN: if ok(j), go to HOLDOFF with hcnt=0.
  - HOLDOFF: if !ok(j), go to DOWN and increment fail_cnt(j). Otherwise hcnt increments; when hcnt is all-ones, go to UP. chan_rdy[j] is high on the first UP cycle, which is exactly 2^HOLDOFF_BITS cycles after HOLDOFF entry.
  - UP: if !ok(j), go to DOWN; lost_cnt[j] increments (saturating at all-ones) only if chan_en[j] was high in that cycle. Disable is not a loss.
- fail_cnt(j): clears on entering UP. When an increment reaches RETRAIN_THRESH, retrain_req[j] pulses for one cycle and fail_cnt clears.
- rdy: registered. Set when enabled mask != 0 and every enabled channel is UP. Lags the last chan_rdy by 1 cycle and drops 1 cycle after any enabled chan_rdy falls.
- Alignment FSM, states IDLE / WINDOW; active only while rdy=1:
  - rise(j) = frame_valid[j] & ~fv_q[j] & chan_en[j].
  - IDLE: any rise -> WINDOW, with seen=rise vector and wcnt=0. If that rise vector already equals the enabled mask, frame_start pulses on the next cycle and the FSM stays IDLE.
  - WINDOW: seen |= rise and wcnt increments.
    - seen == enabled mask (including rises this cycle): frame_start pulse next cycle, go to IDLE.
    - Rise on a channel already in seen: sync_err pulse, go to IDLE. This check takes priority over completion in the same cycle.
    - wcnt == SKEW_MAX-1 without completion: sync_err pulse, go to IDLE.
  - rdy falling mid-window: go to IDLE with no pulse.
  - sync_err_cnt saturates at all-ones.
- WIDTH=1: every rise gives frame_start; sync_err occurs only on the duplicate-rise rule, which cannot happen in IDLE.
- Changing chan_en mid-window: the new mask applies from the next cycle's comparison.

Optional Feature:
Macro MT9V032_LINK_MONITOR_LINE_CHECK_EN.
- Defined: for each enabled channel in UP, line_valid[j] & ~frame_valid[j] in a cycle increments line_err_cnt by 1 (saturating). Multiple channels in the same cycle still count as 1.
- Undefined: line_err_cnt is tied to 0 and no checking logic is built.
- The port exists in both cases.

Test Plan:
- WIDTH=2, HOLDOFF_BITS=4, chan_en=11, train_done and iod_ready raised at cycle 10 -> chan_rdy=11 at cycle 26, rdy=1 at cycle 27.
- train_done[1] drops for 1 cycle while UP -> chan_rdy[1]=0 next cycle, lost_cnt[1]=1, rdy falls, recovery after 16 more cycles.
- Rises on ch0 at t and ch1 at t+5, SKEW_MAX=16 -> single frame_start at t+6, sync_err_cnt unchanged.
- Rise on ch0 only; ch1 silent for 16 cycles -> sync_err pulse at window end, sync_err_cnt=1. Run 300 such errors with ERR_BITS=8 -> count holds at 255.
- train_done[0] toggles low 4 times during HOLDOFF (RETRAIN_THRESH=4) -> exactly one retrain_req[0] pulse on the 4th failure, fail count restarts.
- chan_en=01 with ch1 never trained -> rdy=1 after hold-off; ch0 rises alone give frame_start each time. With macro defined, line_valid[0]=1 while frame_valid[0]=0 for 3 cycles -> line_err_cnt=3.

Source files
------------

// File: rtl/mt9v032_link_monitor_if.sv
// Signal bundle between the per-camera deserializer/post-processing outputs and
// the link monitor; the monitor sits on the slave side.
interface mt9v032_link_monitor_if #(
  parameter int WIDTH    = 2,
  parameter int ERR_BITS = 8
);
  logic [WIDTH-1:0]          chan_en;
  logic [WIDTH-1:0]          train_done;
  logic                      iod_ready;
  logic [WIDTH-1:0]          frame_valid;
  logic [WIDTH-1:0]          line_valid;

  logic [WIDTH-1:0]          chan_rdy;
  logic                      rdy;
  logic                      frame_start;
  logic                      sync_err;
  logic [ERR_BITS-1:0]       sync_err_cnt;
  logic [WIDTH*ERR_BITS-1:0] lost_cnt;
  logic [WIDTH-1:0]          retrain_req;
  logic [ERR_BITS-1:0]       line_err_cnt;

  // Debug taps: 2 state bits per channel FSM, 1 bit for the alignment FSM.
  logic [2*WIDTH-1:0]        chan_state;
  logic                      align_state;

  modport master (
    output chan_en, train_done, iod_ready, frame_valid, line_valid,
    input  chan_rdy, rdy, frame_start, sync_err, sync_err_cnt, lost_cnt,
    input  retrain_req, line_err_cnt, chan_state, align_state
  );

  modport slave (
    input  chan_en, train_done, iod_ready, frame_valid, line_valid,
    output chan_rdy, rdy, frame_start, sync_err, sync_err_cnt, lost_cnt,
    output retrain_req, line_err_cnt, chan_state, align_state
  );
endinterface

// File: rtl/mt9v032_link_monitor.sv
// Multi-camera link health and frame-alignment monitor (clk_px domain).
// Optional line_valid-outside-frame checking: MT9V032_LINK_MONITOR_LINE_CHECK_EN.
module mt9v032_link_monitor #(
  parameter int WIDTH          = 2,
  parameter int HOLDOFF_BITS   = 12,
  parameter int SKEW_MAX       = 16,
  parameter int ERR_BITS       = 8,
  parameter int RETRAIN_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mt9v032_link_monitor_if.slave bus
);

  localparam int FAIL_BITS = $clog2(RETRAIN_THRESH + 1);
  localparam int WCNT_BITS = (SKEW_MAX > 1) ? $clog2(SKEW_MAX) : 1;

  localparam logic [HOLDOFF_BITS-1:0] HCNT_LAST  = '1;
  localparam logic [FAIL_BITS-1:0]    FAIL_LIMIT = FAIL_BITS'(RETRAIN_THRESH);
  localparam logic [ERR_BITS-1:0]     ERR_MAX    = '1;
  localparam logic [WCNT_BITS-1:0]    WCNT_LAST  = WCNT_BITS'(SKEW_MAX - 1);

  typedef enum logic [1:0] {
    CH_DOWN    = 2'd0,
    CH_HOLDOFF = 2'd1,
    CH_UP      = 2'd2
  } chan_state_t;

  typedef enum logic {
    AL_IDLE   = 1'b0,
    AL_WINDOW = 1'b1
  } align_state_t;

  // ---------------------------------------------------------------------------
  // Per-channel link FSMs
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]        ok;
  chan_state_t             ch_q    [WIDTH];
  chan_state_t             ch_d    [WIDTH];
  logic [HOLDOFF_BITS-1:0] hcnt_q  [WIDTH];
  logic [HOLDOFF_BITS-1:0] hcnt_d  [WIDTH];
  logic [FAIL_BITS-1:0]    fail_q  [WIDTH];
  logic [FAIL_BITS-1:0]    fail_d  [WIDTH];
  logic [ERR_BITS-1:0]     lost_q  [WIDTH];
  logic [ERR_BITS-1:0]     lost_d  [WIDTH];
  logic [WIDTH-1:0]        retrain_d;
  logic [WIDTH-1:0]        retrain_q;
  logic [WIDTH-1:0]        chan_rdy;
  logic                    rdy_q;

  assign ok = bus.chan_en & bus.train_done & {WIDTH{bus.iod_ready}};

  always_comb begin
    for (int j = 0; j < WIDTH; j++) begin
      ch_d[j]      = ch_q[j];
      hcnt_d[j]    = hcnt_q[j];
      fail_d[j]    = fail_q[j];
      lost_d[j]    = lost_q[j];
      retrain_d[j] = 1'b0;
      unique case (ch_q[j])
        CH_DOWN: begin
          if (ok[j]) begin
            ch_d[j]   = CH_HOLDOFF;
            hcnt_d[j] = '0;
          end
        end
        CH_HOLDOFF: begin
          if (!ok[j]) begin
            ch_d[j] = CH_DOWN;
            if (fail_q[j] + FAIL_BITS'(1) == FAIL_LIMIT) begin
              retrain_d[j] = 1'b1;
              fail_d[j]    = '0;
            end else begin
              fail_d[j] = fail_q[j] + FAIL_BITS'(1);
            end
          end else begin
            // The DOWN cycle that saw ok counts as the first hold-off cycle,
            // so UP follows 2^HOLDOFF_BITS cycles after ok first appeared.
            hcnt_d[j] = hcnt_q[j] + HOLDOFF_BITS'(1);
            if (hcnt_q[j] + HOLDOFF_BITS'(1) == HCNT_LAST) begin
              ch_d[j]   = CH_UP;
              fail_d[j] = '0;
            end
          end
        end
        CH_UP: begin
          if (!ok[j]) begin
            ch_d[j] = CH_DOWN;
            // A channel dropped by its enable is not a link loss.
            if (bus.chan_en[j] && (lost_q[j] != ERR_MAX)) begin
              lost_d[j] = lost_q[j] + ERR_BITS'(1);
            end
          end
        end
        default: begin
          ch_d[j] = CH_DOWN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < WIDTH; j++) begin
        ch_q[j]   <= CH_DOWN;
        hcnt_q[j] <= '0;
        fail_q[j] <= '0;
        lost_q[j] <= '0;
      end
      retrain_q <= '0;
      rdy_q     <= 1'b0;
    end else begin
      for (int j = 0; j < WIDTH; j++) begin
        ch_q[j]   <= ch_d[j];
        hcnt_q[j] <= hcnt_d[j];
        fail_q[j] <= fail_d[j];
        lost_q[j] <= lost_d[j];
      end
      retrain_q <= retrain_d;
      rdy_q     <= (|bus.chan_en) && ((chan_rdy & bus.chan_en) == bus.chan_en);
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan_out
    assign chan_rdy[g]                            = (ch_q[g] == CH_UP);
    assign bus.lost_cnt[g*ERR_BITS +: ERR_BITS]   = lost_q[g];
    assign bus.chan_state[2*g +: 2]               = ch_q[g];
  end

  // ---------------------------------------------------------------------------
  // Frame alignment FSM
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]     fv_q;
  logic [WIDTH-1:0]     rise;
  logic [WIDTH-1:0]     seen_q;
  logic [WIDTH-1:0]     seen_d;
  logic [WIDTH-1:0]     seen_or;
  logic [WCNT_BITS-1:0] wcnt_q;
  logic [WCNT_BITS-1:0] wcnt_d;
  align_state_t         al_q;
  align_state_t         al_d;
  logic                 fs_d;
  logic                 fs_q;
  logic                 se_d;
  logic                 se_q;
  logic [ERR_BITS-1:0]  se_cnt_q;

  assign rise    = bus.frame_valid & ~fv_q & bus.chan_en;
  assign seen_or = seen_q | rise;

  always_comb begin
    al_d   = al_q;
    seen_d = seen_q;
    wcnt_d = wcnt_q;
    fs_d   = 1'b0;
    se_d   = 1'b0;
    if (!rdy_q) begin
      al_d = AL_IDLE;
    end else begin
      unique case (al_q)
        AL_IDLE: begin
          if (|rise) begin
            if (rise == bus.chan_en) begin
              fs_d = 1'b1;
            end else begin
              al_d   = AL_WINDOW;
              seen_d = rise;
              wcnt_d = '0;
            end
          end
        end
        AL_WINDOW: begin
          wcnt_d = wcnt_q + WCNT_BITS'(1);
          // A second rise on an already-seen channel wins over completion.
          if (|(rise & seen_q)) begin
            se_d = 1'b1;
            al_d = AL_IDLE;
          end else if (seen_or == bus.chan_en) begin
            fs_d = 1'b1;
            al_d = AL_IDLE;
          end else if (wcnt_q == WCNT_LAST) begin
            se_d = 1'b1;
            al_d = AL_IDLE;
          end else begin
            seen_d = seen_or;
          end
        end
        default: begin
          al_d = AL_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fv_q     <= '1;
      al_q     <= AL_IDLE;
      seen_q   <= '0;
      wcnt_q   <= '0;
      fs_q     <= 1'b0;
      se_q     <= 1'b0;
      se_cnt_q <= '0;
    end else begin
      fv_q   <= bus.frame_valid;
      al_q   <= al_d;
      seen_q <= seen_d;
      wcnt_q <= wcnt_d;
      fs_q   <= fs_d;
      se_q   <= se_d;
      if (se_d && (se_cnt_q != ERR_MAX)) begin
        se_cnt_q <= se_cnt_q + ERR_BITS'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional line_valid-outside-frame checker
  // ---------------------------------------------------------------------------
`ifdef MT9V032_LINK_MONITOR_LINE_CHECK_EN
  logic [WIDTH-1:0]    line_bad;
  logic [ERR_BITS-1:0] line_err_q;

  assign line_bad = bus.chan_en & chan_rdy & bus.line_valid & ~bus.frame_valid;

  // Several offending channels in one cycle still count once.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_err_q <= '0;
    end else if ((|line_bad) && (line_err_q != ERR_MAX)) begin
      line_err_q <= line_err_q + ERR_BITS'(1);
    end
  end

  assign bus.line_err_cnt = line_err_q;
`else
  logic unused_line_valid;
  assign unused_line_valid = ^bus.line_valid;
  assign bus.line_err_cnt  = '0;
`endif

  assign bus.chan_rdy     = chan_rdy;
  assign bus.rdy          = rdy_q;
  assign bus.frame_start  = fs_q;
  assign bus.sync_err     = se_q;
  assign bus.sync_err_cnt = se_cnt_q;
  assign bus.retrain_req  = retrain_q;
  assign bus.align_state  = al_q;

endmodule

// File: tb/tb_mt9v032_link_monitor.sv
// Self-checking bench for mt9v032_link_monitor: directed test-plan cases with
// literal expectations, then randomized traffic against a behavioural model.
module tb_mt9v032_link_monitor;

  localparam int WIDTH          = 2;
  localparam int HOLDOFF_BITS   = 4;
  localparam int SKEW_MAX       = 16;
  localparam int ERR_BITS       = 8;
  localparam int RETRAIN_THRESH = 4;
  localparam int HOLD           = 1 << HOLDOFF_BITS;
  localparam int ERR_MAX        = (1 << ERR_BITS) - 1;

  typedef struct packed {
    logic [WIDTH-1:0]          chan_rdy;
    logic                      rdy;
    logic                      frame_start;
    logic                      sync_err;
    logic [ERR_BITS-1:0]       sync_err_cnt;
    logic [WIDTH*ERR_BITS-1:0] lost_cnt;
    logic [WIDTH-1:0]          retrain_req;
    logic [ERR_BITS-1:0]       line_err_cnt;
  } exp_t;
  localparam int W = $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mt9v032_link_monitor_if #(.WIDTH(WIDTH), .ERR_BITS(ERR_BITS)) bus ();

  mt9v032_link_monitor #(
    .WIDTH(WIDTH), .HOLDOFF_BITS(HOLDOFF_BITS), .SKEW_MAX(SKEW_MAX),
    .ERR_BITS(ERR_BITS), .RETRAIN_THRESH(RETRAIN_THRESH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // A channel is up once it has been continuously ok for HOLD cycles.
  int               run   [WIDTH];
  int               fails [WIDTH];
  int               lost  [WIDTH];
  logic [WIDTH-1:0] m_chan_rdy = '0;
  logic [WIDTH-1:0] m_retrain  = '0;
  logic [WIDTH-1:0] m_fv_prev  = '1;
  logic [WIDTH-1:0] m_seen     = '0;
  logic             m_rdy      = 1'b0;
  logic             m_fs       = 1'b0;
  logic             m_se       = 1'b0;
  logic             m_win_open = 1'b0;
  int               m_se_cnt   = 0;
  int               m_line_cnt = 0;
  int               m_win_start = 0;
  int               cyc        = 0;

  logic [W-1:0] exp_q[$];

  task automatic model_step();
    logic [WIDTH-1:0] en, okv, rise, nxt_chan_rdy, nxt_retrain;
    logic nxt_rdy, nxt_fs, nxt_se;
    cyc++;
    if (rst) begin
      for (int j = 0; j < WIDTH; j++) begin
        run[j] = 0; fails[j] = 0; lost[j] = 0;
      end
      m_chan_rdy = '0; m_retrain = '0; m_fv_prev = '1; m_seen = '0;
      m_rdy = 0; m_fs = 0; m_se = 0; m_win_open = 0;
      m_se_cnt = 0; m_line_cnt = 0;
      return;
    end
    en  = bus.chan_en;
    okv = bus.chan_en & bus.train_done & {WIDTH{bus.iod_ready}};
    nxt_retrain = '0;
    for (int j = 0; j < WIDTH; j++) begin
      if (okv[j]) begin
        run[j] = (run[j] < HOLD) ? run[j] + 1 : HOLD;
      end else begin
        if (run[j] >= HOLD) begin
          if (en[j] && lost[j] < ERR_MAX) lost[j]++;
        end else if (run[j] > 0) begin
          fails[j]++;
          if (fails[j] == RETRAIN_THRESH) begin
            nxt_retrain[j] = 1'b1;
            fails[j] = 0;
          end
        end
        run[j] = 0;
      end
      nxt_chan_rdy[j] = (run[j] >= HOLD);
      if (nxt_chan_rdy[j] && !m_chan_rdy[j]) fails[j] = 0;
    end
    nxt_rdy = (en != 0) && ((m_chan_rdy & en) == en);

    rise   = bus.frame_valid & ~m_fv_prev & en;
    nxt_fs = 1'b0;
    nxt_se = 1'b0;
    if (!m_rdy) begin
      m_win_open = 1'b0;
    end else if (!m_win_open) begin
      if (rise != 0) begin
        if (rise == en) nxt_fs = 1'b1;
        else begin
          m_win_open = 1'b1; m_win_start = cyc; m_seen = rise;
        end
      end
    end else begin
      if ((rise & m_seen) != 0) begin
        nxt_se = 1'b1; m_win_open = 1'b0;
      end else if ((m_seen | rise) == en) begin
        nxt_fs = 1'b1; m_win_open = 1'b0;
      end else if (cyc - m_win_start >= SKEW_MAX) begin
        nxt_se = 1'b1; m_win_open = 1'b0;
      end else begin
        m_seen = m_seen | rise;
      end
    end
    if (nxt_se && m_se_cnt < ERR_MAX) m_se_cnt++;
`ifdef MT9V032_LINK_MONITOR_LINE_CHECK_EN
    if (((m_chan_rdy & en & bus.line_valid & ~bus.frame_valid) != 0) && m_line_cnt < ERR_MAX)
      m_line_cnt++;
`endif
    m_fv_prev  = bus.frame_valid;
    m_chan_rdy = nxt_chan_rdy;
    m_retrain  = nxt_retrain;
    m_rdy      = nxt_rdy;
    m_fs       = nxt_fs;
    m_se       = nxt_se;
  endtask

  // ---------------- scoreboard: model step then compare every cycle ----------------
  always @(posedge clk) begin
    exp_t e;
    exp_t x;
    model_step();
    e.chan_rdy     = m_chan_rdy;
    e.rdy          = m_rdy;
    e.frame_start  = m_fs;
    e.sync_err     = m_se;
    e.sync_err_cnt = ERR_BITS'(m_se_cnt);
    for (int j = 0; j < WIDTH; j++) e.lost_cnt[j*ERR_BITS +: ERR_BITS] = ERR_BITS'(lost[j]);
    e.retrain_req  = m_retrain;
    e.line_err_cnt = ERR_BITS'(m_line_cnt);
    exp_q.push_back(e);
    #1;
    x = exp_t'(exp_q.pop_front());
    check("chan_rdy",     64'(bus.chan_rdy),     64'(x.chan_rdy));
    check("rdy",          64'(bus.rdy),          64'(x.rdy));
    check("frame_start",  64'(bus.frame_start),  64'(x.frame_start));
    check("sync_err",     64'(bus.sync_err),     64'(x.sync_err));
    check("sync_err_cnt", 64'(bus.sync_err_cnt), 64'(x.sync_err_cnt));
    check("lost_cnt",     64'(bus.lost_cnt),     64'(x.lost_cnt));
    check("retrain_req",  64'(bus.retrain_req),  64'(x.retrain_req));
    check("line_err_cnt", 64'(bus.line_err_cnt), 64'(x.line_err_cnt));
  end

  // ---------------- driver tasks ----------------
  task automatic edges(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.chan_en     = '0;
    bus.train_done  = '0;
    bus.iod_ready   = 1'b0;
    bus.frame_valid = '0;
    bus.line_valid  = '0;
    rst = 1'b1;
    edges(3);
    check("reset_chan_rdy", 64'(bus.chan_rdy), 0);
    check("reset_lost_cnt", 64'(bus.lost_cnt), 0);
    at_neg();
    rst = 1'b0;

    // Bring-up: hold-off of 16 cycles, rdy one cycle later.
    repeat (9) at_neg();
    bus.chan_en = 2'b11; bus.train_done = 2'b11; bus.iod_ready = 1'b1;
    edges(15);
    check("holdoff_not_yet", 64'(bus.chan_rdy), 64'h0);
    edges(1);
    check("holdoff_done", 64'(bus.chan_rdy), 64'h3);
    check("rdy_lags", 64'(bus.rdy), 64'h0);
    edges(1);
    check("rdy_up", 64'(bus.rdy), 64'h1);

    // One-cycle loss on channel 1.
    at_neg(); bus.train_done = 2'b01;
    edges(1);
    check("loss_chan_rdy", 64'(bus.chan_rdy), 64'h1);
    check("loss_lost_cnt", 64'(bus.lost_cnt), 64'h0100);
    at_neg(); bus.train_done = 2'b11;
    edges(1);
    check("loss_rdy_fall", 64'(bus.rdy), 64'h0);
    edges(14);
    check("recover_not_yet", 64'(bus.chan_rdy), 64'h1);
    edges(1);
    check("recover_chan_rdy", 64'(bus.chan_rdy), 64'h3);
    edges(1);
    check("recover_rdy", 64'(bus.rdy), 64'h1);

    // Aligned frame: ch0 at t, ch1 at t+5.
    at_neg(); bus.frame_valid = 2'b01;
    repeat (5) at_neg();
    bus.frame_valid = 2'b11;
    edges(1);
    check("aligned_frame_start", 64'(bus.frame_start), 64'h1);
    check("aligned_no_err", 64'(bus.sync_err_cnt), 64'h0);
    edges(1);
    check("frame_start_one_cycle", 64'(bus.frame_start), 64'h0);
    at_neg(); bus.frame_valid = 2'b00;
    repeat (3) at_neg();

    // Skew timeout: ch0 alone.
    bus.frame_valid = 2'b01;
    edges(16);
    check("skew_not_yet", 64'(bus.sync_err), 64'h0);
    edges(1);
    check("skew_sync_err", 64'(bus.sync_err), 64'h1);
    check("skew_err_cnt", 64'(bus.sync_err_cnt), 64'h1);
    at_neg(); bus.frame_valid = 2'b00;
    for (int i = 0; i < 299; i++) begin
      at_neg(); bus.frame_valid = 2'b01;
      repeat (18) at_neg();
      bus.frame_valid = 2'b00;
    end
    edges(1);
    check("err_cnt_saturates", 64'(bus.sync_err_cnt), 64'hff);

    // Retrain on the 4th hold-off failure, then the count restarts.
    at_neg(); bus.train_done = 2'b10;
    for (int i = 0; i < 7; i++) begin
      repeat (2) at_neg();
      bus.train_done = 2'b11;
      repeat (3) at_neg();
      bus.train_done = 2'b10;
      edges(1);
      check("retrain_req", 64'(bus.retrain_req), (i == 3) ? 64'h1 : 64'h0);
    end
    at_neg(); bus.train_done = 2'b11;
    edges(20);

    // Single enabled channel, ch1 never trained.
    at_neg(); rst = 1'b1;
    edges(2);
    at_neg(); rst = 1'b0;
    bus.chan_en = 2'b01; bus.train_done = 2'b01; bus.iod_ready = 1'b1;
    bus.frame_valid = 2'b00; bus.line_valid = 2'b00;
    edges(17);
    check("single_rdy", 64'(bus.rdy), 64'h1);
    for (int i = 0; i < 3; i++) begin
      at_neg(); bus.frame_valid = 2'b01;
      edges(1);
      check("single_frame_start", 64'(bus.frame_start), 64'h1);
      at_neg(); bus.frame_valid = 2'b00;
      edges(1);
    end
    at_neg(); bus.line_valid = 2'b01;
    repeat (3) at_neg();
    bus.line_valid = 2'b00;
    edges(1);
`ifdef MT9V032_LINK_MONITOR_LINE_CHECK_EN
    check("line_err_cnt", 64'(bus.line_err_cnt), 64'h3);
`else
    check("line_err_cnt_off", 64'(bus.line_err_cnt), 64'h0);
`endif

    // Randomized traffic checked by the model.
    at_neg();
    bus.chan_en = 2'b11; bus.train_done = 2'b11; bus.iod_ready = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      at_neg();
      rst = ($urandom_range(0, 1499) == 0);
      for (int j = 0; j < WIDTH; j++) begin
        if ($urandom_range(0, 249) == 0) bus.chan_en[j]     = ~bus.chan_en[j];
        if ($urandom_range(0, 39) == 0)  bus.train_done[j]  = ~bus.train_done[j];
        if ($urandom_range(0, 9) == 0)   bus.frame_valid[j] = ~bus.frame_valid[j];
        bus.line_valid[j] = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 399) == 0) bus.iod_ready = ~bus.iod_ready;
    end
    at_neg(); rst = 1'b0;
    edges(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
